// File: rtl/instr_decode_seq.sv
// Serial instruction decoder: assembles 16-bit words from CHUNK_W-bit beats (LSB chunk first),
// fetches a second immediate word for I/M types, and presents registered decode fields.
module instr_decode_seq #(
    parameter int INSTR_W = 16,
    parameter int CHUNK_W = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CHUNK_W-1:0] in_data,
    output logic               dec_valid,
    input  logic               dec_ready,
    output logic [2:0]         opcode,
    output logic [2:0]         rs1,
    output logic [2:0]         rs2,
    output logic [2:0]         rd,
    output logic [3:0]         alu_op,
    output logic [3:0]         mem_op,
    output logic [2:0]         b_type,
    output logic               jump_type,
    output logic [8:0]         offset,
    output logic [INSTR_W-1:0] imm,
    output logic               dbl_word,
    output logic               use_imm,
    output logic               use_addr,
    output logic               rf_write,
    output logic               illegal,
    output logic               halt
);
    localparam int BEATS = INSTR_W / CHUNK_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    localparam logic [1:0] W0     = 2'd0;
    localparam logic [1:0] W1     = 2'd1;
    localparam logic [1:0] OUT    = 2'd2;
    localparam logic [1:0] HALTED = 2'd3;

    localparam logic [2:0] OP_R   = 3'd0;
    localparam logic [2:0] OP_I   = 3'd1;
    localparam logic [2:0] OP_B   = 3'd2;
    localparam logic [2:0] OP_J   = 3'd3;
    localparam logic [2:0] OP_M   = 3'd4;
    localparam logic [2:0] OP_END = 3'd5;

    logic [1:0]         state_q;
    logic [CNT_W-1:0]   beat_q;
    logic [INSTR_W-1:0] shift_q;
    logic [INSTR_W-1:0] instr_q;
    logic [INSTR_W-1:0] shifted;
    logic               accept;
    logic               last;
    logic               first_dbl;
    logic               load;

    // New chunk enters at the top so the first (LSB) chunk ends up in the low bits.
    generate
        if (CHUNK_W == INSTR_W) begin : g_full
            assign shifted = in_data;
        end else begin : g_shift
            assign shifted = {in_data, shift_q[INSTR_W-1:CHUNK_W]};
        end
    endgenerate

    assign in_ready  = (state_q == W0) || (state_q == W1);
    assign dec_valid = (state_q == OUT);
    assign accept    = in_valid && in_ready;
    assign last      = accept && (beat_q == LAST_BEAT);
    assign first_dbl = (shifted[2:0] == OP_I) || (shifted[2:0] == OP_M);
    assign load      = last && (((state_q == W0) && !first_dbl) || (state_q == W1));

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= W0;
            beat_q  <= '0;
            shift_q <= '0;
            instr_q <= '0;
        end else begin
            case (state_q)
                W0, W1: begin
                    if (accept) begin
                        shift_q <= shifted;
                        beat_q  <= last ? '0 : beat_q + 1'b1;
                    end
                    if (last) begin
                        if (state_q == W0 && first_dbl) begin
                            instr_q <= shifted;
                            state_q <= W1;
                        end else begin
                            state_q <= OUT;
                        end
                    end
                end
                OUT: begin
                    if (dec_ready) state_q <= (opcode == OP_END) ? HALTED : W0;
                end
                default: state_q <= HALTED;
            endcase
        end
    end

    logic [INSTR_W-1:0] src;
    logic [2:0]         d_rs1, d_rs2, d_rd, d_b_type;
    logic [3:0]         d_alu_op, d_mem_op;
    logic               d_jump_type, d_dbl, d_use_imm, d_use_addr, d_rf_write, d_illegal;
    logic [8:0]         d_offset;

    assign src = (state_q == W0) ? shifted : instr_q;

    always_comb begin
        d_rs1       = '0;
        d_rs2       = '0;
        d_rd        = '0;
        d_b_type    = '0;
        d_alu_op    = '0;
        d_mem_op    = '0;
        d_jump_type = 1'b0;
        d_offset    = '0;
        d_dbl       = 1'b0;
        d_use_imm   = 1'b0;
        d_use_addr  = 1'b0;
        d_rf_write  = 1'b0;
        d_illegal   = 1'b0;
        case (src[2:0])
            OP_R: begin
                d_rs1      = src[5:3];
                d_rs2      = src[8:6];
                d_rd       = src[11:9];
                d_alu_op   = src[15:12];
                d_rf_write = 1'b1;
            end
            OP_I: begin
                d_rs1      = src[5:3];
                d_rd       = src[11:9];
                d_alu_op   = src[15:12];
                d_use_imm  = 1'b1;
                d_dbl      = 1'b1;
                d_rf_write = 1'b1;
            end
            OP_B: begin
                d_rs1    = src[5:3];
                d_rs2    = src[8:6];
                d_offset = {5'b0, src[12:9]};
                d_b_type = src[15:13];
            end
            OP_J: begin
                d_offset    = {src[15:12], src[8:4]};
                d_jump_type = src[6];
                d_rd        = src[11:9];
            end
            OP_M: begin
                d_rd       = src[11:9];
                d_rs1      = src[5:3];
                d_rs2      = src[8:6];
                d_mem_op   = src[15:12];
                d_use_addr = 1'b1;
                d_dbl      = 1'b1;
                d_rf_write = (src[15:12] <= 4'd2);
            end
            OP_END: ;
            default: d_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            opcode    <= '0;
            rs1       <= '0;
            rs2       <= '0;
            rd        <= '0;
            alu_op    <= '0;
            mem_op    <= '0;
            b_type    <= '0;
            jump_type <= 1'b0;
            offset    <= '0;
            imm       <= '0;
            dbl_word  <= 1'b0;
            use_imm   <= 1'b0;
            use_addr  <= 1'b0;
            rf_write  <= 1'b0;
            illegal   <= 1'b0;
            halt      <= 1'b0;
        end else if (load) begin
            opcode    <= src[2:0];
            rs1       <= d_rs1;
            rs2       <= d_rs2;
            rd        <= d_rd;
            alu_op    <= d_alu_op;
            mem_op    <= d_mem_op;
            b_type    <= d_b_type;
            jump_type <= d_jump_type;
            offset    <= d_offset;
            imm       <= (state_q == W1) ? shifted : '0;
            dbl_word  <= d_dbl;
            use_imm   <= d_use_imm;
            use_addr  <= d_use_addr;
            rf_write  <= d_rf_write;
            illegal   <= d_illegal;
            if (src[2:0] == OP_END) halt <= 1'b1;
        end
    end
endmodule
